// File: rtl/pid_loop_sequencer.sv
// Sample-loop scheduler for the wall-follower PID: trigger sensor, wait for a range reading,
// strobe one PID update per period, and apply gain changes only at period boundaries.
module pid_loop_sequencer #(
    parameter int PV_WIDTH       = 9,
    parameter int PID_INT_WIDTH  = 8,
    parameter int SAMPLE_CYCLES  = 5_000_000,
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 3_000_000,
    parameter int MAX_MISSES     = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     gain_wr,
    input  logic [PID_INT_WIDTH-1:0] k_p_in,
    input  logic [PID_INT_WIDTH-1:0] k_i_in,
    input  logic [PID_INT_WIDTH-1:0] k_d_in,
    input  logic                     meas_valid,
    input  logic [PV_WIDTH-1:0]      meas_dist,
    output logic                     sensor_trig,
    output logic [PV_WIDTH-1:0]      feedback_out,
    output logic                     pid_en,
    output logic                     pid_clk_en,
    output logic [PID_INT_WIDTH-1:0] k_p,
    output logic [PID_INT_WIDTH-1:0] k_i,
    output logic [PID_INT_WIDTH-1:0] k_d,
    output logic                     fault,
    output logic [15:0]              update_count
);

    localparam int PER_W  = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int MISS_W = $clog2(MAX_MISSES + 1);

    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(SAMPLE_CYCLES - 1);
    localparam logic [PER_W-1:0]  TRIG_LAST = PER_W'(TRIG_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [MISS_W-1:0] MISS_MAX  = MISS_W'(MAX_MISSES);

    if (SAMPLE_CYCLES <= TRIG_CYCLES + TIMEOUT_CYCLES + 2) begin : g_bad_timing
        $error("SAMPLE_CYCLES must exceed TRIG_CYCLES + TIMEOUT_CYCLES + 2");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_TRIG, S_WAIT, S_UPDATE, S_HOLD, S_FAULT
    } state_t;

    state_t                 state_q, state_d;
    logic [PER_W-1:0]       period_q, period_d;
    logic [TO_W-1:0]        timeout_q, timeout_d;
    logic [MISS_W-1:0]      miss_q, miss_d;
    logic [PV_WIDTH-1:0]    feedback_q, feedback_d;
    logic [15:0]            update_count_q, update_count_d;
    logic [PID_INT_WIDTH-1:0] k_p_q, k_p_d, k_i_q, k_i_d, k_d_q, k_d_d;
    logic [PID_INT_WIDTH-1:0] sh_kp_q, sh_kp_d, sh_ki_q, sh_ki_d, sh_kd_q, sh_kd_d;
    logic                   pending_q, pending_d;
    logic                   sensor_trig_q, sensor_trig_d;
    logic                   pid_en_q, pid_en_d;
    logic                   pid_clk_en_q, pid_clk_en_d;
    logic                   fault_q, fault_d;
    logic                   trig_entry;
    logic [MISS_W-1:0]      miss_inc;

    // First TRIG cycle of a period: the only point where active gains may change mid-run.
    assign trig_entry = (state_q == S_TRIG) && (period_q == '0);
    assign miss_inc   = miss_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        miss_d         = miss_q;
        feedback_d     = feedback_q;
        update_count_d = update_count_q;
        k_p_d          = k_p_q;
        k_i_d          = k_i_q;
        k_d_d          = k_d_q;
        sh_kp_d        = sh_kp_q;
        sh_ki_d        = sh_ki_q;
        sh_kd_d        = sh_kd_q;
        pending_d      = pending_q;

        if (!run) begin
            state_d = S_IDLE;
            miss_d  = '0;
        end else begin
            case (state_q)
                S_IDLE:   state_d = S_TRIG;
                S_TRIG:   if (period_q == TRIG_LAST) state_d = S_WAIT;
                S_WAIT: begin
                    if (meas_valid) begin
                        feedback_d     = meas_dist;
                        miss_d         = '0;
                        update_count_d = update_count_q + 16'd1;
                        state_d        = S_UPDATE;
                    end else if (timeout_q == TO_LAST) begin
                        miss_d  = miss_inc;
                        state_d = (miss_inc >= MISS_MAX) ? S_FAULT : S_HOLD;
                    end
                end
                S_UPDATE: state_d = S_HOLD;
                S_HOLD:   if (period_q == PER_LAST) state_d = S_TRIG;
                S_FAULT:  state_d = S_FAULT;
                default:  state_d = S_IDLE;
            endcase
        end

        if (state_q == S_IDLE || state_q == S_FAULT || trig_entry) begin
            if (trig_entry && pending_q) begin
                k_p_d = sh_kp_q;
                k_i_d = sh_ki_q;
                k_d_d = sh_kd_q;
            end
            if (trig_entry) pending_d = 1'b0;
            if (gain_wr) begin
                k_p_d = k_p_in;
                k_i_d = k_i_in;
                k_d_d = k_d_in;
            end
        end else if (gain_wr) begin
            sh_kp_d   = k_p_in;
            sh_ki_d   = k_i_in;
            sh_kd_d   = k_d_in;
            pending_d = 1'b1;
        end

        if ((state_d == S_TRIG && state_q != S_TRIG) || state_d == S_IDLE || state_d == S_FAULT)
            period_d = '0;
        else
            period_d = period_q + 1'b1;

        timeout_d = (state_q == S_WAIT) ? timeout_q + 1'b1 : '0;

        sensor_trig_d = (state_d == S_TRIG);
        pid_clk_en_d  = (state_d == S_UPDATE);
        fault_d       = (state_d == S_FAULT);
        pid_en_d      = (state_d == S_TRIG) || (state_d == S_WAIT) ||
                        (state_d == S_UPDATE) || (state_d == S_HOLD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            period_q       <= '0;
            timeout_q      <= '0;
            miss_q         <= '0;
            feedback_q     <= '0;
            update_count_q <= '0;
            k_p_q          <= '0;
            k_i_q          <= '0;
            k_d_q          <= '0;
            sh_kp_q        <= '0;
            sh_ki_q        <= '0;
            sh_kd_q        <= '0;
            pending_q      <= 1'b0;
            sensor_trig_q  <= 1'b0;
            pid_en_q       <= 1'b0;
            pid_clk_en_q   <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            period_q       <= period_d;
            timeout_q      <= timeout_d;
            miss_q         <= miss_d;
            feedback_q     <= feedback_d;
            update_count_q <= update_count_d;
            k_p_q          <= k_p_d;
            k_i_q          <= k_i_d;
            k_d_q          <= k_d_d;
            sh_kp_q        <= sh_kp_d;
            sh_ki_q        <= sh_ki_d;
            sh_kd_q        <= sh_kd_d;
            pending_q      <= pending_d;
            sensor_trig_q  <= sensor_trig_d;
            pid_en_q       <= pid_en_d;
            pid_clk_en_q   <= pid_clk_en_d;
            fault_q        <= fault_d;
        end
    end

    assign sensor_trig  = sensor_trig_q;
    assign feedback_out = feedback_q;
    assign pid_en       = pid_en_q;
    assign pid_clk_en   = pid_clk_en_q;
    assign k_p          = k_p_q;
    assign k_i          = k_i_q;
    assign k_d          = k_d_q;
    assign fault        = fault_q;
    assign update_count = update_count_q;

endmodule

// File: tb/tb_pid_loop_sequencer.sv
// Directed bench for pid_loop_sequencer with a short sample period (100 cycles, 4-cycle trigger,
// 50-cycle timeout); t below is the cycle index from the first TRIG cycle of a period.
module tb_pid_loop_sequencer;

    logic       clk = 1'b0;
    logic       reset, run, gain_wr, meas_valid;
    logic [7:0] k_p_in, k_i_in, k_d_in;
    logic [8:0] meas_dist;
    logic       sensor_trig, pid_en, pid_clk_en, fault;
    logic [8:0] feedback_out;
    logic [7:0] k_p, k_i, k_d;
    logic [15:0] update_count;

    int total = 0;
    int bad   = 0;
    int ntrig = 0;
    int nclk  = 0;

    always #5 clk = ~clk;

    pid_loop_sequencer #(
        .PV_WIDTH(9), .PID_INT_WIDTH(8), .SAMPLE_CYCLES(100),
        .TRIG_CYCLES(4), .TIMEOUT_CYCLES(50), .MAX_MISSES(3)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .gain_wr(gain_wr),
        .k_p_in(k_p_in), .k_i_in(k_i_in), .k_d_in(k_d_in),
        .meas_valid(meas_valid), .meas_dist(meas_dist),
        .sensor_trig(sensor_trig), .feedback_out(feedback_out), .pid_en(pid_en),
        .pid_clk_en(pid_clk_en), .k_p(k_p), .k_i(k_i), .k_d(k_d),
        .fault(fault), .update_count(update_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ntrig += int'(sensor_trig);
        nclk  += int'(pid_clk_en);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; gain_wr = 1'b0; meas_valid = 1'b0;
        k_p_in = 8'd0; k_i_in = 8'd0; k_d_in = 8'd0; meas_dist = 9'd0;
        #12;
        chk("rst_trig",   32'(sensor_trig),  0);
        chk("rst_pid_en", 32'(pid_en),       0);
        chk("rst_clk_en", 32'(pid_clk_en),   0);
        chk("rst_fault",  32'(fault),        0);
        chk("rst_fb",     32'(feedback_out), 0);
        chk("rst_kp",     32'(k_p),          0);
        chk("rst_count",  32'(update_count), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // IDLE: gains load straight to active
        gain_wr = 1'b1; k_p_in = 8'd3; k_i_in = 8'd4; k_d_in = 8'd5;
        step();
        gain_wr = 1'b0;
        chk("idle_kp", 32'(k_p), 3);
        chk("idle_ki", 32'(k_i), 4);
        chk("idle_kd", 32'(k_d), 5);
        chk("idle_pid_en", 32'(pid_en), 0);

        // Period 1: nominal measurement at t=20
        run = 1'b1; ntrig = 0; nclk = 0;
        step();
        chk("p1_trig_t0", 32'(sensor_trig), 1);
        chk("p1_pid_en",  32'(pid_en), 1);
        steps(20);
        chk("p1_trig_len", 32'(ntrig), 4);
        meas_valid = 1'b1; meas_dist = 9'd150;
        step();
        meas_valid = 1'b0;
        chk("nom_fb",     32'(feedback_out), 150);
        chk("nom_clk_en", 32'(pid_clk_en),   1);
        chk("nom_count",  32'(update_count), 1);
        ntrig = 0; nclk = 0;
        steps(9);
        k_p_in = 8'd10; gain_wr = 1'b1;
        step();
        gain_wr = 1'b0;
        chk("hold_kp_kept", 32'(k_p), 3);
        steps(68);
        chk("p1_single_clk_en", 32'(nclk), 0);
        chk("p1_no_retrig",     32'(ntrig), 0);
        chk("p1_kp_t99",        32'(k_p), 3);
        step();
        chk("p2_trig_t100", 32'(sensor_trig), 1);
        chk("p2_kp_t0",     32'(k_p), 3);
        step();
        chk("p2_kp_t1", 32'(k_p), 10);
        chk("p2_ki_t1", 32'(k_i), 4);

        // Period 2: timeout, no update, feedback held
        nclk = 0;
        steps(98);
        chk("miss_no_clk_en", 32'(nclk), 0);
        chk("miss_fb",        32'(feedback_out), 150);
        chk("miss_pid_en",    32'(pid_en), 1);
        step();
        chk("p3_trig", 32'(sensor_trig), 1);

        // Period 3: valid on the timeout cycle (t=53) wins
        steps(53);
        meas_valid = 1'b1; meas_dist = 9'd200;
        step();
        meas_valid = 1'b0;
        chk("race_clk_en", 32'(pid_clk_en),   1);
        chk("race_fb",     32'(feedback_out), 200);
        chk("race_count",  32'(update_count), 2);
        steps(46);
        chk("p4_trig", 32'(sensor_trig), 1);

        // Periods 4-6 miss; fault only after the third consecutive miss
        steps(99);
        step();
        steps(99);
        chk("p5_no_fault", 32'(fault), 0);
        step();
        chk("p6_trig", 32'(sensor_trig), 1);
        steps(53);
        chk("p6_pre_fault",  32'(fault),  0);
        chk("p6_pre_pid_en", 32'(pid_en), 1);
        step();
        chk("fault_set",    32'(fault),  1);
        chk("fault_pid_en", 32'(pid_en), 0);
        ntrig = 0; nclk = 0;
        steps(150);
        chk("fault_no_trig",   32'(ntrig), 0);
        chk("fault_no_clk_en", 32'(nclk),  0);
        chk("fault_sticky",    32'(fault), 1);
        run = 1'b0;
        step();
        chk("fault_clr", 32'(fault), 0);
        run = 1'b1;
        step();
        chk("resume_trig", 32'(sensor_trig), 1);

        // gain_wr on the first TRIG cycle goes active directly
        gain_wr = 1'b1; k_p_in = 8'd7;
        step();
        gain_wr = 1'b0;
        chk("entry_kp", 32'(k_p), 7);

        // Abort during TRIG cycle 2
        step();
        chk("abort_trig_pre", 32'(sensor_trig), 1);
        run = 1'b0;
        step();
        chk("abort_trig",   32'(sensor_trig), 0);
        chk("abort_pid_en", 32'(pid_en), 0);
        step();
        chk("abort_idle_trig", 32'(sensor_trig), 0);

        // Async reset in WAIT
        run = 1'b1;
        step();
        steps(10);
        chk("wait_pid_en", 32'(pid_en), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_pid_en", 32'(pid_en),       0);
        chk("arst_kp",     32'(k_p),          0);
        chk("arst_fb",     32'(feedback_out), 0);
        chk("arst_count",  32'(update_count), 0);
        chk("arst_trig",   32'(sensor_trig),  0);
        ntrig = 0; nclk = 0;
        steps(3);
        chk("arst_no_trig",   32'(ntrig), 0);
        chk("arst_no_clk_en", 32'(nclk),  0);

        // update_count wrap
        reset = 1'b0; run = 1'b0;
        force dut.update_count_q = 16'hFFFF;
        step();
        release dut.update_count_q;
        step();
        chk("wrap_pre", 32'(update_count), 32'hFFFF);
        run = 1'b1;
        step();
        steps(9);
        meas_valid = 1'b1; meas_dist = 9'd33;
        step();
        meas_valid = 1'b0;
        chk("wrap_clk_en", 32'(pid_clk_en),   1);
        chk("wrap_count",  32'(update_count), 0);
        chk("wrap_fb",     32'(feedback_out), 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
